// File: rtl/axil_irq_ctrl.sv
// ---------------------------------------------------------------------------
// axil_irq_ctrl : 32-line edge-triggered interrupt controller, AXI-Lite slave
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axil_irq_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       src,
  output logic [31:0]       irq,
  input  logic [31:0]       eoi,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, WRESP = 2'd1, RRESP = 2'd2} state_t;

  state_t      state;
  logic [31:0] src_q, eoi_q;
  logic [31:0] pending, enable, autoclr;
  logic [15:0] eoicnt;

  logic [IDX_W-1:0] widx, ridx;
  logic [31:0] wmask, wd, rise, efall, set_v, clr_v, pend_nxt, rd_data;
  logic        wr_commit, wr_err, rd_err;
  logic        w_pend, w_en, w_ac, w_set;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  always_comb begin
    wmask     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    wd        = wdata & wmask;
    wr_commit = (state == IDLE) && awready;
    widx      = awaddr[ADDR_W-1:2];
    ridx      = araddr[ADDR_W-1:2];
    wr_err    = 1'b1;
    w_pend    = 1'b0;
    w_en      = 1'b0;
    w_ac      = 1'b0;
    w_set     = 1'b0;
    case (widx)
      IDX_W'(0): begin wr_err = 1'b0; w_pend = wr_commit; end
      IDX_W'(1): begin wr_err = 1'b0; w_en   = wr_commit; end
      IDX_W'(2): begin wr_err = 1'b0; w_ac   = wr_commit; end
      IDX_W'(4): begin wr_err = 1'b0; w_set  = wr_commit; end
      default:   wr_err = 1'b1;
    endcase

    rise     = src & ~src_q;
    efall    = eoi_q & ~eoi;
    // Sets are applied after clears so a same-cycle set always wins.
    set_v    = rise | (w_set ? wd : 32'h0);
    clr_v    = (w_pend ? wd : 32'h0) | (efall & autoclr);
    pend_nxt = (pending & ~clr_v) | set_v;

    rd_err  = 1'b0;
    rd_data = 32'h0;
    case (ridx)
      IDX_W'(0): rd_data = pending;
      IDX_W'(1): rd_data = enable;
      IDX_W'(2): rd_data = autoclr;
      IDX_W'(3): rd_data = pending & enable;
      IDX_W'(4): rd_data = 32'h0;
      IDX_W'(5): rd_data = {16'h0, eoicnt};
      default:   rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= src;
      eoi_q   <= eoi;
      pending <= 32'h0;
      enable  <= 32'h0;
      autoclr <= 32'h0;
      eoicnt  <= 16'h0;
      irq     <= 32'h0;
    end else begin
      src_q   <= src;
      eoi_q   <= eoi;
      pending <= pend_nxt;
      irq     <= pending & enable;
      if (w_en) enable  <= (enable & ~wmask) | wd;
      if (w_ac) autoclr <= (autoclr & ~wmask) | wd;
      if (|efall) eoicnt <= eoicnt + 16'd1;
    end
  end

  // Ready strobes are raised for one cycle; the handshake edge is the one after.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      arready <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      rvalid  <= 1'b0;
      rresp   <= OKAY;
      rdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (awready) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_err ? SLVERR : OKAY;
            state   <= WRESP;
          end else if (arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_data;
            rresp   <= rd_err ? SLVERR : OKAY;
            state   <= RRESP;
          end else if (awvalid && wvalid) begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end else if (arvalid) begin
            arready <= 1'b1;
          end
        end
        WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        RRESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axil_irq_ctrl : directed self-checking bench for axil_irq_ctrl
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axil_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src, eoi, irq;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;
  logic [1:0]  r;

  axil_irq_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .src(src), .irq(irq), .eoi(eoi),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] dat, input logic [3:0] s,
                           input int bdelay, input logic [31:0] hs_src, output logic [1:0] resp);
    int n;
    awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("aw_handshake", {31'h0, awready}, 32'h1);
    src = src | hs_src;
    cyc(1);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (bdelay > 0) begin
      cyc(bdelay);
      check("bvalid_hold", {31'h0, bvalid}, 32'h1);
    end
    resp = bresp;
    bready = 1'b1;
    cyc(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    cyc(1);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check("rvalid_seen", {31'h0, rvalid}, 32'h1);
    dat = rdata; resp = rresp;
    rready = 1'b1;
    cyc(1);
    rready = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] dat);
    logic [1:0] rs;
    axi_write(a, dat, 4'hF, 0, 32'h0, rs);
    check("wr_okay", {30'h0, rs}, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    logic [1:0]  rs;
    axi_read(a, v, rs);
    check(tag, v, exp);
  endtask

  initial begin
    int n;
    reset = 1'b1; src = 32'h2; eoi = 32'h0;
    awaddr = 8'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = 8'h0; arvalid = 1'b0; rready = 1'b0;
    cyc(3);
    check("rst_irq", irq, 32'h0);
    check("rst_valids", {28'h0, bvalid, rvalid, awready, arready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    cyc(2);
    rd_chk("no_spurious_edge", 8'h00, 32'h0);
    rd_chk("rst_enable", 8'h04, 32'h0);

    // Basic edge capture and irq latency.
    wr(8'h04, 32'h1);
    src[0] = 1'b1;
    cyc(1);
    check("irq_lag", irq, 32'h0);
    cyc(1);
    check("irq_set", irq, 32'h1);
    src[0] = 1'b0;
    rd_chk("pending_0", 8'h00, 32'h1);
    rd_chk("active_0", 8'h0C, 32'h1);

    // W1C coinciding with a new rise: set wins.
    axi_write(8'h00, 32'h1, 4'hF, 0, 32'h1, r);
    check("w1c_race_bresp", {30'h0, r}, 32'h0);
    rd_chk("set_wins", 8'h00, 32'h1);
    src[0] = 1'b0;
    wr(8'h00, 32'h1);
    rd_chk("w1c_clear", 8'h00, 32'h0);

    // Autoclear via eoi falling edge, plus counter.
    wr(8'h08, 32'h4);
    wr(8'h04, 32'h4);
    wr(8'h10, 32'h4);
    cyc(2);
    check("irq_bit2", irq, 32'h4);
    eoi[2] = 1'b1; cyc(2);
    eoi[2] = 1'b0; cyc(2);
    check("irq_autoclr", irq, 32'h0);
    rd_chk("pend_autoclr", 8'h00, 32'h0);
    rd_chk("eoicnt_1", 8'h14, 32'h1);
    wr(8'h10, 32'h20);
    eoi[5] = 1'b1; cyc(2);
    eoi[5] = 1'b0; cyc(2);
    rd_chk("no_autoclr_bit5", 8'h00, 32'h20);
    rd_chk("eoicnt_2", 8'h14, 32'h2);

    // Byte-lane strobes.
    wr(8'h04, 32'h0);
    axi_write(8'h04, 32'hFFFF_FFFF, 4'b0010, 0, 32'h0, r);
    rd_chk("enable_strb", 8'h04, 32'h0000_FF00);
    axi_write(8'h10, 32'hFFFF_FFFF, 4'b0001, 0, 32'h0, r);
    rd_chk("set_strb", 8'h00, 32'h0000_00FF);

    // Error responses and a stalled bready.
    axi_read(8'h20, d, r);
    check("unmapped_rresp", {30'h0, r}, 32'h2);
    check("unmapped_rdata", d, 32'h0);
    axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 5, 32'h0, r);
    check("ro_bresp", {30'h0, r}, 32'h2);
    rd_chk("active_unchanged", 8'h0C, 32'h0);
    rd_chk("pend_unchanged", 8'h00, 32'h0000_00FF);
    wr(8'h00, 32'hFFFF_FFFF);
    rd_chk("level_no_reset", 8'h00, 32'h0);

    // Write wins over a simultaneous read; reset aborts the read response.
    awaddr = 8'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("arb_awready", {31'h0, awready}, 32'h1);
    check("arb_no_arready", {31'h0, arready}, 32'h0);
    cyc(1);
    awvalid = 1'b0; wvalid = 1'b0;
    check("arb_bvalid", {31'h0, bvalid}, 32'h1);
    bready = 1'b1; cyc(1); bready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    cyc(1);
    arvalid = 1'b0;
    check("arb_rvalid", {31'h0, rvalid}, 32'h1);
    check("arb_read_after_write", rdata, 32'h55);
    reset = 1'b1;
    cyc(1);
    check("rst_aborts_rvalid", {31'h0, rvalid}, 32'h0);
    reset = 1'b0;
    cyc(1);
    rd_chk("enable_after_rst", 8'h04, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
